// File: rtl/coin_panel_ctrl.sv
// rtl/coin_panel_ctrl.sv - front-panel and coin-acceptor controller for the washing machine controller
//
// Tracks paid credit, prices the latched mode, raises start for a whole run,
// and meters coin ejection for refunds and rejected coins.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   coin_in               one-cycle pulse per inserted coin
//   mode_sel, mode_req    panel selector (00 none, 01..11 mode1..3) and latch pulse
//   start_req, cancel_req panel button pulses
//   idle_op, coin_rtrn    status from the washing machine controller
//   start                 level, high for the whole run
//   cancel                one-cycle pulse to the controller during a run
//   mode1..mode3          one-hot latched mode
//   credit                current credit in coins
//   coin_eject            one-cycle pulse per returned coin
//   coin_block            coin slot shutter closed (RUNNING, REFUND)
//   ready, busy           ARMED / RUNNING-or-REFUND indicators
module coin_panel_ctrl #(
  parameter int PRICE1    = 2,
  parameter int PRICE2    = 3,
  parameter int PRICE3    = 5,
  parameter int CREDIT_W  = 4,
  parameter int EJECT_GAP = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_in,
  input  logic [1:0]          mode_sel,
  input  logic                mode_req,
  input  logic                start_req,
  input  logic                cancel_req,
  input  logic                idle_op,
  input  logic                coin_rtrn,
  output logic                start,
  output logic                cancel,
  output logic                mode1,
  output logic                mode2,
  output logic                mode3,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_eject,
  output logic                coin_block,
  output logic                ready,
  output logic                busy
);

  localparam int GAP_W = (EJECT_GAP > 1) ? $clog2(EJECT_GAP + 1) : 1;
  localparam logic [CREDIT_W-1:0] MAX_CREDIT = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ARMED,
    S_RUNNING,
    S_REFUND
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d, mode_new;
  logic                seen_busy_q, seen_busy_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [CREDIT_W-1:0] credit_d;
  logic                start_d, cancel_d, eject_d;
  logic                coin_ok;
  logic [CREDIT_W:0]   cur_price, new_price, credit_eff, credit_left;
  logic [CREDIT_W-1:0] credit_back;

  function automatic logic [CREDIT_W:0] price_of(input logic [1:0] m);
    case (m)
      2'b01:   price_of = (CREDIT_W+1)'(PRICE1);
      2'b10:   price_of = (CREDIT_W+1)'(PRICE2);
      2'b11:   price_of = (CREDIT_W+1)'(PRICE3);
      default: price_of = '0;
    endcase
  endfunction

  // Credit arithmetic is one bit wider so coin+start can go below/above range safely.
  assign coin_ok     = coin_in && (credit != MAX_CREDIT);
  assign credit_eff  = {1'b0, credit} + {{CREDIT_W{1'b0}}, coin_ok};
  assign cur_price   = price_of(mode_q);
  assign mode_new    = mode_req ? mode_sel : mode_q;
  assign new_price   = price_of(mode_new);
  assign credit_left = credit_eff - cur_price;
  // Refund restores exactly what the start took, so it cannot exceed max credit.
  assign credit_back = credit + cur_price[CREDIT_W-1:0];

  always_comb begin
    state_d     = state_q;
    credit_d    = credit;
    mode_d      = mode_q;
    seen_busy_d = seen_busy_q;
    gap_d       = gap_q;
    start_d     = start;
    cancel_d    = 1'b0;
    eject_d     = 1'b0;

    case (state_q)
      S_IDLE, S_SELECT, S_ARMED: begin
        // A coin at max credit is handed straight back.
        eject_d = coin_in && !coin_ok;
        if (cancel_req) begin
          mode_d   = 2'b00;
          credit_d = credit_eff[CREDIT_W-1:0];
          gap_d    = '0;
          state_d  = (credit_eff != '0) ? S_REFUND : S_IDLE;
        end else if (start_req && (mode_q != 2'b00) && (credit_eff >= cur_price)) begin
          credit_d    = credit_left[CREDIT_W-1:0];
          start_d     = 1'b1;
          seen_busy_d = 1'b0;
          state_d     = S_RUNNING;
        end else begin
          credit_d = credit_eff[CREDIT_W-1:0];
          mode_d   = mode_new;
          if (mode_new == 2'b00)
            state_d = S_IDLE;
          else
            state_d = (credit_eff >= new_price) ? S_ARMED : S_SELECT;
        end
      end
      S_RUNNING: begin
        if (!idle_op) seen_busy_d = 1'b1;
        if (cancel_req) cancel_d = 1'b1;
        if (coin_rtrn) begin
          credit_d = credit_back;
          start_d  = 1'b0;
          gap_d    = '0;
          state_d  = S_REFUND;
        end else if (seen_busy_q && idle_op) begin
          // Controller went busy and came back idle: run finished.
          start_d = 1'b0;
          mode_d  = 2'b00;
          state_d = S_IDLE;
        end
      end
      S_REFUND: begin
        if (credit == '0) begin
          mode_d  = 2'b00;
          state_d = S_IDLE;
        end else if (gap_q == '0) begin
          eject_d  = 1'b1;
          credit_d = credit - 1'b1;
          gap_d    = GAP_W'(EJECT_GAP);
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'b00;
      seen_busy_q <= 1'b0;
      gap_q       <= '0;
      credit      <= '0;
      start       <= 1'b0;
      cancel      <= 1'b0;
      coin_eject  <= 1'b0;
      mode1       <= 1'b0;
      mode2       <= 1'b0;
      mode3       <= 1'b0;
      coin_block  <= 1'b0;
      ready       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      seen_busy_q <= seen_busy_d;
      gap_q       <= gap_d;
      credit      <= credit_d;
      start       <= start_d;
      cancel      <= cancel_d;
      coin_eject  <= eject_d;
      mode1       <= (mode_d == 2'b01);
      mode2       <= (mode_d == 2'b10);
      mode3       <= (mode_d == 2'b11);
      coin_block  <= (state_d == S_RUNNING) || (state_d == S_REFUND);
      ready       <= (state_d == S_ARMED);
      busy        <= (state_d == S_RUNNING) || (state_d == S_REFUND);
    end
  end

endmodule

// File: tb/tb_coin_panel_ctrl.sv
// tb/tb_coin_panel_ctrl.sv - self-checking bench for coin_panel_ctrl
module tb_coin_panel_ctrl;

  localparam int P1 = 2, P2 = 3, P3 = 5, CW = 4, GAP = 3;
  localparam int MAXC = (1 << CW) - 1;
  localparam int PH_IDLE = 0, PH_SELECT = 1, PH_ARMED = 2, PH_RUN = 3, PH_REFUND = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic coin_in = 0, mode_req = 0, start_req = 0, cancel_req = 0, idle_op = 1, coin_rtrn = 0;
  logic [1:0] mode_sel = 2'b00;
  logic start, cancel, mode1, mode2, mode3, coin_eject, coin_block, ready, busy;
  logic [CW-1:0] credit;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: plain integers.
  int m_credit, m_mode, m_phase, m_refund_t;
  bit m_seen, e_start, e_cancel, e_eject;

  coin_panel_ctrl #(.PRICE1(P1), .PRICE2(P2), .PRICE3(P3), .CREDIT_W(CW), .EJECT_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .coin_in(coin_in), .mode_sel(mode_sel), .mode_req(mode_req),
    .start_req(start_req), .cancel_req(cancel_req), .idle_op(idle_op), .coin_rtrn(coin_rtrn),
    .start(start), .cancel(cancel), .mode1(mode1), .mode2(mode2), .mode3(mode3),
    .credit(credit), .coin_eject(coin_eject), .coin_block(coin_block), .ready(ready), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int price(input int m);
    return (m == 1) ? P1 : (m == 2) ? P2 : (m == 3) ? P3 : 0;
  endfunction

  task automatic model_reset();
    m_credit = 0; m_mode = 0; m_phase = PH_IDLE; m_refund_t = 0;
    m_seen = 0; e_start = 0; e_cancel = 0; e_eject = 0;
  endtask

  task automatic model_step(input bit ci, input int ms, input bit mr, input bit sr,
                            input bit cr, input bit io, input bit rt);
    int c1;
    e_cancel = 0;
    e_eject  = 0;
    if (m_phase <= PH_ARMED) begin
      c1 = (ci && m_credit < MAXC) ? m_credit + 1 : m_credit;
      e_eject = ci && (m_credit == MAXC);
      if (cr) begin
        m_mode = 0; m_credit = c1; m_refund_t = 0;
        m_phase = (c1 > 0) ? PH_REFUND : PH_IDLE;
      end else if (sr && m_mode != 0 && c1 >= price(m_mode)) begin
        m_credit = c1 - price(m_mode); e_start = 1; m_seen = 0; m_phase = PH_RUN;
      end else begin
        m_credit = c1;
        if (mr) m_mode = ms;
        if (m_mode == 0) m_phase = PH_IDLE;
        else m_phase = (c1 >= price(m_mode)) ? PH_ARMED : PH_SELECT;
      end
    end else if (m_phase == PH_RUN) begin
      if (cr) e_cancel = 1;
      if (rt) begin
        m_credit += price(m_mode); e_start = 0; m_refund_t = 0; m_phase = PH_REFUND;
      end else if (m_seen && io) begin
        e_start = 0; m_mode = 0; m_phase = PH_IDLE;
      end
      if (!io) m_seen = 1;
    end else begin
      // Ejects land on every (GAP+1)-th refund cycle counted from the first one.
      if (m_credit == 0) begin
        m_mode = 0; m_phase = PH_IDLE;
      end else begin
        if (m_refund_t % (GAP + 1) == 0) begin
          e_eject = 1; m_credit--;
        end
        m_refund_t++;
      end
    end
  endtask

  task automatic compare_all();
    check("start", start, e_start);
    check("cancel", cancel, e_cancel);
    check("coin_eject", coin_eject, e_eject);
    check("credit", credit, m_credit);
    check("mode1", mode1, m_mode == 1);
    check("mode2", mode2, m_mode == 2);
    check("mode3", mode3, m_mode == 3);
    check("ready", ready, m_phase == PH_ARMED);
    check("busy", busy, m_phase >= PH_RUN);
    check("coin_block", coin_block, m_phase >= PH_RUN);
  endtask

  task automatic tick(input bit ci, input int ms, input bit mr, input bit sr,
                      input bit cr, input bit io, input bit rt);
    coin_in = ci; mode_sel = ms[1:0]; mode_req = mr; start_req = sr;
    cancel_req = cr; idle_op = io; coin_rtrn = rt;
    @(posedge clk);
    model_step(ci, ms, mr, sr, cr, io, rt);
    @(negedge clk);
    coin_in = 0; mode_req = 0; start_req = 0; cancel_req = 0; coin_rtrn = 0; idle_op = 1;
    compare_all();
  endtask

  task automatic idle_tick(); tick(0, 0, 0, 0, 0, 1, 0); endtask
  task automatic coin();      tick(1, 0, 0, 0, 0, 1, 0); endtask
  task automatic sel(input int m); tick(0, m, 1, 0, 0, 1, 0); endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    compare_all();
  endtask

  // Ticks until the DUT drops busy; counts ejects and checks their spacing.
  task automatic run_until_idle(output int ejects);
    int last;
    int k;
    ejects = 0; last = -1; k = 0;
    while (k < 200 && (k == 0 || busy)) begin
      idle_tick();
      if (coin_eject) begin
        if (last >= 0) check("eject_period", cyc - last, GAP + 1);
        last = cyc;
        ejects++;
      end
      k++;
    end
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    int ej;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rst = 0;

    // Async reset in the middle of a refund with credit 3.
    sel(1); coin(); coin(); coin();
    tick(0, 0, 0, 0, 1, 1, 0);
    check("pre_rst_credit", credit, 3);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1;
    #1;
    check("rst_credit", credit, 0);
    check("rst_eject", coin_eject, 0);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_modes", {mode1, mode2, mode3}, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    coin();
    check("post_rst_coin", credit, 1);
    do_reset();

    // mode1 run to completion.
    sel(1); coin();
    check("sel_ready0", ready, 0);
    coin();
    check("armed_ready", ready, 1);
    tick(0, 0, 0, 1, 0, 1, 0);
    check("run_start", start, 1);
    check("run_mode1", mode1, 1);
    check("run_credit", credit, 0);
    repeat (5) tick(0, 0, 0, 0, 0, 0, 0);
    idle_tick();
    check("done_start", start, 0);
    check("done_mode1", mode1, 0);
    check("done_ready", ready, 0);
    check("done_busy", busy, 0);

    // mode3 underpaid, cancel refunds 3 coins.
    sel(3); coin(); coin(); coin();
    check("m3_ready", ready, 0);
    tick(0, 0, 0, 0, 1, 1, 0);
    run_until_idle(ej);
    check("m3_ejects", ej, 3);
    check("m3_credit", credit, 0);

    // mode2 run, cancel pulse, coin return.
    sel(2); coin(); coin(); coin(); coin();
    tick(0, 0, 0, 1, 0, 1, 0);
    check("m2_credit", credit, 1);
    tick(0, 0, 0, 0, 1, 1, 0);
    check("m2_cancel", cancel, 1);
    idle_tick();
    check("m2_cancel_end", cancel, 0);
    tick(0, 0, 0, 0, 0, 1, 1);
    check("rtrn_start", start, 0);
    check("rtrn_credit", credit, 4);
    run_until_idle(ej);
    check("rtrn_ejects", ej, 4);

    // Saturation and coins during a run.
    repeat (15) coin();
    check("sat_credit", credit, MAXC);
    coin();
    check("sat_eject", coin_eject, 1);
    check("sat_credit2", credit, MAXC);
    sel(1);
    tick(0, 0, 0, 1, 0, 1, 0);
    repeat (3) coin();
    check("run_block", coin_block, 1);
    check("run_credit_hold", credit, MAXC - P1);
    tick(0, 0, 0, 0, 0, 0, 0);
    run_until_idle(ej);
    do_reset();

    // coin+start together, then start+cancel together.
    sel(1); coin(); coin();
    tick(1, 0, 0, 1, 0, 1, 0);
    check("cs_credit", credit, 1);
    check("cs_start", start, 1);
    tick(0, 0, 0, 0, 0, 0, 0);
    run_until_idle(ej);
    sel(1); coin();
    tick(0, 0, 0, 1, 1, 1, 0);
    check("sc_start", start, 0);
    check("sc_busy", busy, 1);
    run_until_idle(ej);
    check("sc_ejects", ej, 2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
